// File: rtl/mp1_mem_responder.sv
// mp1_mem_responder: word-addressed memory slave for the multicycle RV32I core.
// Handshake: the master raises mem_read or mem_write with stable address/data
// and holds them until it sees the one-cycle mem_resp pulse; the responder
// accepts in IDLE, completes LATENCY cycles later, and ignores anything
// presented during the RESP cycle itself (that is the request being completed).
module mp1_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           mem_address,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_byte_enable,
    output logic [31:0]           mem_rdata,
    output logic                  mem_resp,
    output logic                  protocol_err,
    output logic [1:0]            dbg_state
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  is_write_q, is_write_d;
    logic                  resp_q, resp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  perr_q, perr_d;

    logic [31:0]           mem [DEPTH];

    // Values used by the completing edge: live inputs when LATENCY=1 (accept
    // and complete coincide), captured holding registers otherwise.
    logic                  enter_resp;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_be;
    logic                  cur_is_write;
    logic                  mem_we;
    logic                  req_held;

    // Next-state, holding-register, and completion logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        is_write_d   = is_write_q;
        resp_d       = 1'b0;
        rdata_d      = rdata_q;
        perr_d       = perr_q;
        enter_resp   = 1'b0;
        cur_idx      = addr_q[ADDR_WIDTH+1:2];
        cur_wdata    = wdata_q;
        cur_be       = be_q;
        cur_is_write = is_write_q;
        req_held     = is_write_q ? mem_write : mem_read;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d     = mem_address;
                    wdata_d    = mem_wdata;
                    be_d       = mem_byte_enable;
                    // Simultaneous read and write is a violation; degrade to a read.
                    is_write_d = mem_write & ~mem_read;
                    cnt_d      = CNT_LOAD;
                    if (mem_read && mem_write) begin
                        perr_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d      = ST_RESP;
                        enter_resp   = 1'b1;
                        cur_idx      = mem_address[ADDR_WIDTH+1:2];
                        cur_wdata    = mem_wdata;
                        cur_be       = mem_byte_enable;
                        cur_is_write = mem_write & ~mem_read;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Master must hold the request stable; completion still uses captured values.
                if (!req_held || (mem_address != addr_q)) begin
                    perr_d = 1'b1;
                end
                if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            resp_d = 1'b1;
            if (!cur_is_write) begin
                rdata_d = mem[cur_idx];
            end
        end

        // Reset gating keeps a LATENCY=1 write from landing while held in reset.
        mem_we = enter_resp & cur_is_write & rst;
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            is_write_q <= 1'b0;
            resp_q     <= 1'b0;
            rdata_q    <= 32'd0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            is_write_q <= is_write_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            perr_q     <= perr_d;
        end
    end

    // Storage array: byte-lane write on the edge entering RESP; contents are never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem_rdata    = rdata_q;
    assign mem_resp     = resp_q;
    assign protocol_err = perr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mp1_mem_responder.sv
// Directed bench for mp1_mem_responder: three instances at LATENCY 3, 1 and 15,
// each with its own request bus, sharing clock and reset.
module tb_mp1_mem_responder;

    localparam int N = 3;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd    [N];
    logic        wr    [N];
    logic [31:0] addr  [N];
    logic [31:0] wdata [N];
    logic [3:0]  be    [N];
    logic [31:0] rdata [N];
    logic        resp  [N];
    logic        perr  [N];
    logic [1:0]  dbg   [N];

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] model [N][8];
    logic [31:0] exp_q [$];

    // clock / reset block
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mp1_mem_responder #(
            .ADDR_WIDTH(10),
            .LATENCY   ((g == 0) ? 3 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .mem_read       (rd[g]),
            .mem_write      (wr[g]),
            .mem_address    (addr[g]),
            .mem_wdata      (wdata[g]),
            .mem_byte_enable(be[g]),
            .mem_rdata      (rdata[g]),
            .mem_resp       (resp[g]),
            .protocol_err   (perr[g]),
            .dbg_state      (dbg[g])
        );
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 3 : ((s == 1) ? 1 : 15);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver: present a request in the current cycle, wait for mem_resp, keep
    // the request held through RESP and return one cycle later (inputs still held).
    task automatic xfer(input int s, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, output logic [31:0] q);
        int cyc;
        rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d; be[s] = b;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!resp[s] && cyc < 40);
        q = rdata[s];
        check_eq("resp_latency", 32'(cyc), 32'(lat_of(s)));
        @(posedge clk); #1;
        check_eq("resp_width", {31'd0, resp[s]}, 32'd0);
        check_eq("post_resp_state", {30'd0, dbg[s]}, 32'd0);
    endtask

    task automatic drop(input int s);
        rd[s] = 1'b0; wr[s] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, d, a;
        logic [3:0]  b;
        int          w, cyc;

        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check_eq("rst_resp", {31'd0, resp[i]}, 32'd0);
            check_eq("rst_rdata", rdata[i], 32'd0);
            check_eq("rst_perr", {31'd0, perr[i]}, 32'd0);
            check_eq("rst_state", {30'd0, dbg[i]}, 32'd0);
        end
        rst = 1'b1;

        // full write then read, LATENCY=3
        xfer(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, q);
        drop(0);
        xfer(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, q);
        check_eq("full_rd", q, 32'hDEAD_BEEF);
        drop(0);

        // partial write of lane 1
        xfer(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010, q);
        drop(0);
        xfer(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, q);
        check_eq("partial_rd", q, 32'hDEAD_AAEF);
        drop(0);

        // address wrap: 0x1000 aliases word 0
        xfer(0, 1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b1111, q);
        drop(0);
        xfer(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'b0000, q);
        check_eq("wrap_rd", q, 32'h1234_5678);
        drop(0);
        check_eq("no_perr_yet", {31'd0, perr[0]}, 32'd0);

        // read and write together: flagged, handled as a read, array untouched
        xfer(0, 1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b1111, q);
        check_eq("both_perr", {31'd0, perr[0]}, 32'd1);
        check_eq("both_as_read", q, 32'hDEAD_AAEF);
        drop(0);
        xfer(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, q);
        check_eq("both_no_write", q, 32'hDEAD_AAEF);
        drop(0);

        // reset in cycle 1 of a write: no response, no commit
        xfer(0, 1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 4'b1111, q);
        drop(0);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h0000_0020; wdata[0] = 32'hCAFE_F00D; be[0] = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0; wr[0] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq("mid_rst_resp", {31'd0, resp[0]}, 32'd0);
            check_eq("mid_rst_rdata", rdata[0], 32'd0);
            check_eq("mid_rst_perr", {31'd0, perr[0]}, 32'd0);
            check_eq("mid_rst_state", {30'd0, dbg[0]}, 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("post_rst_no_resp", {31'd0, resp[0]}, 32'd0);
        end
        xfer(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, q);
        check_eq("rst_no_commit", q, 32'h1111_2222);
        drop(0);

        // random back-to-back traffic at LATENCY=1 (60 ops) and LATENCY=15 (40 ops)
        for (int s = 1; s < N; s++) begin
            for (int i = 0; i < 8; i++) begin
                d = $urandom;
                xfer(s, 1'b0, 1'b1, BASE + 32'(i * 4), d, 4'hF, q);
                model[s][i] = d;
            end
            for (int k = 0; k < ((s == 1) ? 60 : 40); k++) begin
                w = $urandom_range(0, 7);
                a = (32'($urandom_range(0, 255)) << 12) | (BASE + 32'(w * 4)) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) begin
                    d = $urandom;
                    b = 4'($urandom_range(0, 15));
                    for (int l = 0; l < 4; l++) begin
                        if (b[l]) model[s][w][8*l +: 8] = d[8*l +: 8];
                    end
                    xfer(s, 1'b0, 1'b1, a, d, b, q);
                end else begin
                    exp_q.push_back(model[s][w]);
                    xfer(s, 1'b1, 1'b0, a, 32'h0, 4'h0, q);
                    check_eq("sb_read", q, exp_q.pop_front());
                end
                if ($urandom_range(0, 3) == 0) drop(s);
            end
            drop(s);
            check_eq("rand_no_perr", {31'd0, perr[s]}, 32'd0);
        end

        // request dropped while waiting at LATENCY=15: flagged, still completes
        rd[2] = 1'b1; wr[2] = 1'b0; addr[2] = BASE; be[2] = 4'h0;
        @(posedge clk); #1;
        rd[2] = 1'b0;
        cyc = 1;
        while (!resp[2] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("drop_latency", 32'(cyc), 32'd15);
        check_eq("drop_perr", {31'd0, perr[2]}, 32'd1);
        check_eq("drop_rdata", rdata[2], model[2][0]);
        @(posedge clk); #1;
        check_eq("drop_resp_width", {31'd0, resp[2]}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
